ps2_arrow_decoder: RTL and testbench

Receives raw PS/2 keyboard clock/data and deserializes 11-bit frames. Tracks E0 (extended) and F0 (break) prefixes and turns arrow-key make codes into single-cycle turn requests on `move[2:1]`. It sits directly upstream of the snake direction FSM, which consumes `move[2:1]` and produces `direction[1:0]`. A diagnostic byte/valid/error output is also provided for the seven-segment debug display.

---
 rtl/snake_pkg.sv | 23 ++
 rtl/ps2_rx.sv | 103 ++++++++++
 rtl/ps2_arrow_decoder.sv | 80 ++++++++
 tb/tb_ps2_arrow_decoder.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared scan-code constants, prefix-state encoding and arrow lookup for the
// PS/2 front end of the snake game.
package snake_pkg;

  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  typedef enum logic [1:0] {PFX_IDLE, PFX_EXT, PFX_BRK, PFX_EXT_BRK} pfx_t;

  // bit 1 = UP/LEFT, bit 2 = DOWN/RIGHT; never both
  function automatic logic [2:1] arrow_move(input logic [7:0] code);
    case (code)
      SC_UP, SC_LEFT:    return 2'b01;
      SC_DOWN, SC_RIGHT: return 2'b10;
      default:           return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronizes the raw pins, captures 11-bit frames on falling
// ps2_clk edges, checks start/parity/stop and discards stalled partial frames.
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic [7:0] byte_o,
  output logic       byte_vld_o,
  output logic       err_o,
  output logic       tmo_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_prev_q;
  logic [3:0]    cnt_q, cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          vld_q, vld_d, err_q, err_d, tout_q, tout_d;

  logic        fall, bit_in, frame_ok;
  logic [10:0] frame;

  assign fall     = clk_prev_q & ~clk_sync_q[1];
  assign bit_in   = dat_sync_q[1];
  // frame[0]=start, [8:1]=data, [9]=parity, [10]=stop
  assign frame    = {bit_in, shift_q};
  assign frame_ok = ~frame[0] & (^frame[9:1]) & frame[10];

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    tmo_d   = tmo_q;
    byte_d  = byte_q;
    vld_d   = 1'b0;
    err_d   = 1'b0;
    tout_d  = 1'b0;
    if (fall) begin
      shift_d = frame[10:1];
      tmo_d   = '0;
      if (cnt_q == 4'd10) begin
        cnt_d = 4'd0;
        if (frame_ok) begin
          byte_d = frame[8:1];
          vld_d  = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end else if (cnt_q != 4'd0) begin
      if (tmo_q == TMO_LAST) begin
        cnt_d  = 4'd0;
        tmo_d  = '0;
        err_d  = 1'b1;
        tout_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
      cnt_q      <= '0;
      shift_q    <= '0;
      tmo_q      <= '0;
      byte_q     <= '0;
      vld_q      <= 1'b0;
      err_q      <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_data_i};
      clk_prev_q <= clk_sync_q[1];
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      tmo_q      <= tmo_d;
      byte_q     <= byte_d;
      vld_q      <= vld_d;
      err_q      <= err_d;
      tout_q     <= tout_d;
    end
  end

  assign byte_o     = byte_q;
  assign byte_vld_o = vld_q;
  assign err_o      = err_q;
  assign tmo_o      = tout_q;

endmodule

// File: rtl/ps2_arrow_decoder.sv
// PS/2 arrow-key decoder: tracks E0/F0 prefixes on received bytes and emits a
// one-cycle turn request on move, aligned with the code_valid diagnostic pulse.
module ps2_arrow_decoder import snake_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter bit REQUIRE_EXT    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [2:1] move,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  logic [7:0] rx_byte;
  logic       rx_vld, rx_err, rx_tmo;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .rst_n      (reset),
    .ps2_clk_i  (ps2_clk),
    .ps2_data_i (ps2_data),
    .byte_o     (rx_byte),
    .byte_vld_o (rx_vld),
    .err_o      (rx_err),
    .tmo_o      (rx_tmo)
  );

  pfx_t       state_q;
  logic [2:1] move_q;
  logic [7:0] scan_q;
  logic       cv_q, err_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= PFX_IDLE;
      move_q  <= '0;
      scan_q  <= '0;
      cv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      move_q <= '0;
      cv_q   <= rx_vld;
      err_q  <= rx_err;
      if (rx_tmo) begin
        state_q <= PFX_IDLE;
      end else if (rx_vld) begin
        scan_q <= rx_byte;
        case (state_q)
          PFX_IDLE: begin
            if (rx_byte == SC_EXT)      state_q <= PFX_EXT;
            else if (rx_byte == SC_BRK) state_q <= PFX_BRK;
            else begin
              if (!REQUIRE_EXT) move_q <= arrow_move(rx_byte);
              state_q <= PFX_IDLE;
            end
          end
          PFX_EXT: begin
            if (rx_byte == SC_EXT)      state_q <= PFX_EXT;
            else if (rx_byte == SC_BRK) state_q <= PFX_EXT_BRK;
            else begin
              move_q  <= arrow_move(rx_byte);
              state_q <= PFX_IDLE;
            end
          end
          // released key code is swallowed
          default: state_q <= PFX_IDLE;
        endcase
      end
    end
  end

  assign move       = move_q;
  assign scan_code  = scan_q;
  assign code_valid = cv_q;
  assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_arrow_decoder.sv
// Bench for ps2_arrow_decoder: two instances (REQUIRE_EXT 0 and 1) share the
// PS/2 pins; a queue-based model of the prefix rules predicts every pulse.
module tb_ps2_arrow_decoder;

  localparam int TMO  = 300;
  localparam int HALF = 12;

  logic clk = 1'b0, reset = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic [2:1] move0, move1;
  logic [7:0] sc0, sc1;
  logic cv0, cv1, fe0, fe1;

  always #5 clk = ~clk;

  ps2_arrow_decoder #(.TIMEOUT_CYCLES(TMO), .REQUIRE_EXT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .move(move0), .scan_code(sc0), .code_valid(cv0), .frame_err(fe0));

  ps2_arrow_decoder #(.TIMEOUT_CYCLES(TMO), .REQUIRE_EXT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .move(move1), .scan_code(sc1), .code_valid(cv1), .frame_err(fe1));

  int total = 0, bad = 0;

  // observations
  logic [7:0] cv_q[$];
  logic [1:0] mv0_q[$], mv1_q[$];
  time        cv_t_q[$];
  int         err0 = 0, err1 = 0, viol = 0;
  logic [1:0] pmv0 = 2'b00, pmv1 = 2'b00;
  logic       pcv0 = 1'b0;

  // model
  bit         m_ext[2], m_brk[2];
  logic [7:0] exp_cv[$];
  logic [1:0] exp_mv0[$], exp_mv1[$];
  int         exp_err = 0;
  time        last_fall;

  always @(negedge clk) begin
    if (reset) begin
      if (cv0) begin cv_q.push_back(sc0); mv0_q.push_back(move0); cv_t_q.push_back($time); end
      if (cv1) mv1_q.push_back(move1);
      if (fe0) err0++;
      if (fe1) err1++;
      if ((move0 != 2'b00 && !cv0) || (move1 != 2'b00 && !cv1)) viol++;
      if (move0 == 2'b11 || move1 == 2'b11) viol++;
      if ((cv0 && fe0) || (cv1 && fe1) || (cv0 != cv1)) viol++;
      if ((pmv0 != 2'b00 && move0 != 2'b00) || (pmv1 != 2'b00 && move1 != 2'b00)) viol++;
      if (pcv0 && cv0) viol++;
      pmv0 = move0; pmv1 = move1; pcv0 = cv0;
    end
  end

  function automatic logic [1:0] arrow(input logic [7:0] b);
    if (b == 8'h75 || b == 8'h6B) return 2'b01;
    if (b == 8'h72 || b == 8'h74) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    for (int i = 0; i < 2; i++) begin
      logic [1:0] mv;
      mv = 2'b00;
      if (m_brk[i]) begin m_brk[i] = 1'b0; m_ext[i] = 1'b0; end
      else if (b == 8'hE0) m_ext[i] = 1'b1;
      else if (b == 8'hF0) m_brk[i] = 1'b1;
      else begin
        if (m_ext[i] || i == 0) mv = arrow(b);
        m_ext[i] = 1'b0;
      end
      if (i == 0) exp_mv0.push_back(mv); else exp_mv1.push_back(mv);
    end
    exp_cv.push_back(b);
  endtask

  task automatic model_clear_prefix();
    for (int i = 0; i < 2; i++) begin m_ext[i] = 1'b0; m_brk[i] = 1'b0; end
  endtask

  task automatic clear_obs();
    cv_q.delete(); mv0_q.delete(); mv1_q.delete(); cv_t_q.delete();
    exp_cv.delete(); exp_mv0.delete(); exp_mv1.delete();
    err0 = 0; err1 = 0; exp_err = 0;
  endtask

  task automatic send_bits(input logic [10:0] frame, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk) ps2_data = frame[k];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      last_fall = $time;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    @(negedge clk) ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_par);
    logic par;
    par = (~^b) ^ bad_par;
    send_bits({1'b1, par, b, 1'b0}, 11);
    repeat (HALF) @(negedge clk);
    if (bad_par) exp_err++; else model_byte(b);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    if (move0 !== 2'b00 || move1 !== 2'b00) begin bad++; $display("FAIL reset_move got %b/%b want 00", move0, move1); end
    total++;
    if (sc0 !== 8'h00 || sc1 !== 8'h00) begin bad++; $display("FAIL reset_scan got %h/%h want 00", sc0, sc1); end
    total++;
    if ({cv0, cv1, fe0, fe1} !== 4'b0000) begin bad++; $display("FAIL reset_pulses got %b want 0000", {cv0, cv1, fe0, fe1}); end
    total++;
    @(negedge clk) reset = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_ext_up();
    clear_obs();
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    total++;
    if (cv_q.size() !== 2) begin bad++; $display("FAIL ext_up_count got %0d want 2", cv_q.size()); end
    else begin
      total++;
      if (cv_q[0] !== 8'hE0 || cv_q[1] !== 8'h75) begin bad++; $display("FAIL ext_up_bytes got %h %h want e0 75", cv_q[0], cv_q[1]); end
      total++;
      if (mv0_q[0] !== 2'b00 || mv0_q[1] !== 2'b01) begin bad++; $display("FAIL ext_up_move got %b %b want 00 01", mv0_q[0], mv0_q[1]); end
      total++;
      if (cv_t_q[1] - last_fall !== 40) begin bad++; $display("FAIL ext_up_latency got %0t want 40", cv_t_q[1] - last_fall); end
    end
    total++;
    if (sc0 !== 8'h75) begin bad++; $display("FAIL ext_up_hold got %h want 75", sc0); end
  endtask

  task automatic test_ext_break();
    clear_obs();
    send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h74, 1'b0);
    total++;
    if (cv_q.size() !== 3 || mv0_q.size() !== 3) begin bad++; $display("FAIL brk_count got %0d want 3", cv_q.size()); end
    else begin
      total++;
      if ((mv0_q[0] | mv0_q[1] | mv0_q[2] | mv1_q[0] | mv1_q[1] | mv1_q[2]) !== 2'b00) begin
        bad++; $display("FAIL brk_no_move got %b %b %b want 00", mv0_q[0], mv0_q[1], mv0_q[2]);
      end
    end
    clear_obs();
    send_byte(8'hE0, 1'b0); send_byte(8'h74, 1'b0);
    total++;
    if (mv0_q.size() !== 2 || mv0_q[1] !== 2'b10 || mv1_q[1] !== 2'b10) begin
      bad++; $display("FAIL brk_then_right got %0d/%b/%b want 2/10/10", mv0_q.size(), mv0_q[1], mv1_q[1]);
    end
  endtask

  task automatic test_parity_err();
    clear_obs();
    send_byte(8'h6B, 1'b1);
    total++;
    if (err0 !== 1 || err1 !== 1) begin bad++; $display("FAIL parity_err got %0d/%0d want 1", err0, err1); end
    total++;
    if (cv_q.size() !== 0 || sc0 !== 8'h74) begin bad++; $display("FAIL parity_hold got n=%0d sc=%h want 0/74", cv_q.size(), sc0); end
  endtask

  task automatic test_timeout();
    clear_obs();
    send_byte(8'hE0, 1'b0);
    send_bits({1'b1, 1'b1, 8'h55, 1'b0}, 5);
    repeat (TMO - 40) @(negedge clk);
    total++;
    if (err0 !== 0) begin bad++; $display("FAIL timeout_early got %0d want 0", err0); end
    repeat (60) @(negedge clk);
    total++;
    if (err0 !== 1 || err1 !== 1) begin bad++; $display("FAIL timeout_err got %0d/%0d want 1", err0, err1); end
    model_clear_prefix();
    repeat (2 * TMO) @(negedge clk);
    total++;
    if (err0 !== 1) begin bad++; $display("FAIL idle_no_err got %0d want 1", err0); end
    clear_obs();
    send_byte(8'h72, 1'b0);
    total++;
    if (mv0_q.size() !== 1 || mv0_q[0] !== 2'b10 || mv1_q[0] !== 2'b00 || cv_q[0] !== 8'h72) begin
      bad++; $display("FAIL timeout_recover got n=%0d mv=%b/%b want 1 10/00", mv0_q.size(), mv0_q[0], mv1_q[0]);
    end
  endtask

  task automatic test_require_ext();
    clear_obs();
    send_byte(8'h75, 1'b0);
    total++;
    if (mv1_q.size() !== 1 || mv1_q[0] !== 2'b00 || mv0_q[0] !== 2'b01) begin
      bad++; $display("FAIL bare_up got n=%0d mv=%b/%b want 1 01/00", mv1_q.size(), mv0_q[0], mv1_q[0]);
    end
    send_byte(8'hE0, 1'b0); send_byte(8'h75, 1'b0);
    total++;
    if (mv1_q.size() !== 3 || mv1_q[2] !== 2'b01) begin bad++; $display("FAIL req_ext_up got n=%0d mv=%b want 3 01", mv1_q.size(), mv1_q[2]); end
  endtask

  task automatic test_reset_mid_frame();
    send_bits({1'b1, 1'b0, 8'h6B, 1'b0}, 6);
    @(negedge clk) reset = 1'b0;
    #1;
    total++;
    if ({move0, move1, cv0, cv1, fe0, fe1} !== 8'h00 || sc0 !== 8'h00 || sc1 !== 8'h00) begin
      bad++; $display("FAIL midreset_outputs got sc=%h/%h mv=%b/%b want 0", sc0, sc1, move0, move1);
    end
    repeat (4) @(negedge clk);
    reset = 1'b1;
    model_clear_prefix();
    repeat (4) @(negedge clk);
    clear_obs();
    send_byte(8'hE0, 1'b0); send_byte(8'h6B, 1'b0);
    total++;
    if (mv0_q.size() !== 2 || mv0_q[1] !== 2'b01 || mv1_q[1] !== 2'b01 || sc0 !== 8'h6B) begin
      bad++; $display("FAIL midreset_recover got n=%0d mv=%b/%b sc=%h want 2 01/01 6b", mv0_q.size(), mv0_q[1], mv1_q[1], sc0);
    end
  endtask

  task automatic test_random();
    logic [7:0] pool[8];
    pool = '{8'hE0, 8'hF0, 8'h75, 8'h6B, 8'h72, 8'h74, 8'hE0, 8'h1C};
    clear_obs();
    for (int n = 0; n < 45; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      b = (r < 8) ? pool[r] : 8'($urandom);
      send_byte(b, ($urandom_range(0, 7) == 0));
    end
    total++;
    if (cv_q.size() !== exp_cv.size() || mv0_q.size() !== exp_cv.size() || mv1_q.size() !== exp_cv.size()) begin
      bad++; $display("FAIL rand_count got %0d want %0d", cv_q.size(), exp_cv.size());
    end else begin
      for (int i = 0; i < exp_cv.size(); i++) begin
        total++;
        if (cv_q[i] !== exp_cv[i] || mv0_q[i] !== exp_mv0[i] || mv1_q[i] !== exp_mv1[i]) begin
          bad++; $display("FAIL rand_item%0d got %h %b/%b want %h %b/%b", i, cv_q[i], mv0_q[i], mv1_q[i], exp_cv[i], exp_mv0[i], exp_mv1[i]);
        end
      end
    end
    total++;
    if (err0 !== exp_err || err1 !== exp_err) begin bad++; $display("FAIL rand_errs got %0d/%0d want %0d", err0, err1, exp_err); end
  endtask

  initial begin
    model_clear_prefix();
    test_reset();
    test_ext_up();
    test_ext_break();
    test_parity_err();
    test_timeout();
    test_require_ext();
    test_reset_mid_frame();
    test_random();
    total++;
    if (viol !== 0) begin bad++; $display("FAIL pulse_rules got %0d violations want 0", viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
